serial_sub: RTL and testbench
=============================

Name: serial_sub

Overview:
- Bit-serial N-bit subtractor built around a single full-subtractor cell (diff = a^b^bin, bout = ~a&b | ~(a^b)&bin) plus a registered borrow.
- Sits directly upstream of the full-subtractor cell. It loads two parallel operands and feeds the cell one bit pair per clock, LSB first.
- It collects the cell's diff and bout outputs into a parallel result.
- Start/busy/done handshake toward the controlling logic.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled when start is accepted.
- b  input  WIDTH  subtrahend; sampled when start is accepted.
- bin  input  1  initial borrow-in; sampled when start is accepted.
- busy  output  1  high in SHIFT state.
- done  output  1  one-cycle pulse when result is valid.
- diff  output  WIDTH  registered result a - b - bin (mod 2^WIDTH).
- bout  output  1  registered final borrow-out.
- ser_diff  output  1  combinational cell diff for the current bit pair (valid while busy).
- ser_bout  output  1  combinational cell borrow-out for the current bit pair (valid while busy).

Behaviour:
- Reset: one clock, clk; reset is asynchronous, active-low (rst_n). rst_n low forces the following immediately, regardless of clk:
  - state=IDLE; busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow register and bit counter all 0.
  - ser_diff/ser_bout = 0, since they are derived from the cleared registers.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: if start=1 at an edge, latch a->sa, b->sb, bin->br, clear the bit counter, go to SHIFT. Otherwise stay.
  - SHIFT: at each edge, apply the cell to sa[0], sb[0], br:
    - shift the cell diff into the MSB of the result shift register;
    - br <= cell bout;
    - sa, sb shift right by one;
    - counter increments.
    - On the edge that processes bit WIDTH-1, copy the full result into diff, copy the cell bout into bout, and go to DONE.
  - DONE: done=1 for exactly this one cycle, then unconditionally go to IDLE.
- Latency: start accepted at edge E0; bits processed at edges E1..E_WIDTH; done high during the cycle following E_WIDTH. Total WIDTH+1 cycles from start to done; next start can be accepted at edge E_WIDTH+2.
- busy=1 exactly during the WIDTH SHIFT cycles.
- diff/bout hold their previous value throughout an operation. They change only on the completion edge and hold until the next completion or reset.
- ser_diff/ser_bout: combinational from sa[0], sb[0], br. Meaningful only while busy=1; they step through bits 0..WIDTH-1, one per cycle.
- start ignored (no effect, no queuing) in SHIFT and DONE. Changes on a/b/bin after acceptance have no effect.
- Arithmetic: result equals (a - b - bin) mod 2^WIDTH. bout=1 iff a < b + bin (unsigned).
- Reset mid-operation aborts immediately:
  - no done pulse;
  - diff/bout cleared to 0;
  - first start after rst_n deasserts behaves as from power-up.
- WIDTH=1: a single SHIFT cycle; behaviour identical to one full-subtractor evaluation, registered.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, start pulse -> busy high 8 cycles; done in cycle 9 after the start edge; diff=0x02, bout=0; ser_diff sequence (LSB first) 0,1,0,0,0,0,0,0.
- WIDTH=8, a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Then a=0xFF, b=0x00, bin=1 -> diff=0xFE, bout=0.
- WIDTH=8, start a=0x80, b=0x01; re-pulse start with a=0x00, b=0xFF while busy -> ignored; result diff=0x7F, bout=0. Exactly one done pulse; a new start two cycles after done is accepted.
- WIDTH=8, start a=0x10, b=0x20; assert rst_n=0 mid-SHIFT (cycle 4, between edges) -> outputs 0 immediately, no done pulse; restart with a=0x20, b=0x10 -> diff=0x10, bout=0.
- WIDTH=1, all 8 combinations of a, b, bin -> (diff, bout) = 00, 11, 11, 01, 10, 00, 00, 11 in order a b bin = 000..111; done after 2 cycles each.
- Random WIDTH=8 regression, 1000 operations -> diff/bout match (a - b - bin) mod 256 and borrow; done count equals accepted starts.

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial subtractor: feeds one full-subtractor cell LSB first,
// collecting the difference bits and the final borrow into parallel outputs.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ser_diff,
    output logic             ser_bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             cell_diff;
    logic             cell_bout;
    logic [WIDTH-1:0] res_shift;
    logic             last_bit;

    // Single full-subtractor cell on the current bit pair
    assign cell_diff = sa_q[0] ^ sb_q[0] ^ br_q;
    assign cell_bout = (~sa_q[0] & sb_q[0])
                     | (~(sa_q[0] ^ sb_q[0]) & br_q);

    // New diff bit enters at the MSB so bit 0 ends up at the LSB
    assign res_shift = WIDTH'({cell_diff, res_q} >> 1);
    assign last_bit  = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sa_d   = sa_q;
        sb_d   = sb_q;
        res_d  = res_q;
        diff_d = diff_q;
        br_d   = br_q;
        bout_d = bout_q;
        cnt_d  = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d  = a;
                    sb_d  = b;
                    br_d  = bin;
                    cnt_d = '0;
                end
            end
            SHIFT: begin
                res_d = res_shift;
                br_d  = cell_bout;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    diff_d = res_shift;
                    bout_d = cell_bout;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy     = (state_q == SHIFT);
        done     = (state_q == DONE);
        diff     = diff_q;
        bout     = bout_q;
        ser_diff = cell_diff;
        ser_bout = cell_bout;
    end

endmodule

// File: tb/tb_serial_sub.sv
// Directed and random checks of serial_sub at WIDTH=8 and WIDTH=1.
module tb_serial_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start8, bin8, busy8, done8, bout8, sd8, sb8;
    logic [7:0] a8, b8, diff8;
    logic       start1, bin1, busy1, done1, bout1, sd1, sb1;
    logic [0:0] a1, b1, diff1;

    int         total = 0;
    int         bad = 0;
    int         done_cnt = 0;
    int         start_cnt = 0;
    logic [7:0] last_d = '0;
    logic       last_b = 1'b0;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8),
        .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8),
        .ser_diff(sd8), .ser_bout(sb8)
    );

    serial_sub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1),
        .ser_diff(sd1), .ser_bout(sb1)
    );

    always @(posedge clk) if (done8) done_cnt++;

    task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                        input logic bi, input logic [7:0] ed,
                        input logic eb, output logic [7:0] ser);
        @(negedge clk);
        start8 = 1'b1; a8 = av; b8 = bv; bin8 = bi;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'b1;
        start_cnt++;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                bad++;
                $display("FAIL busy bit%0d: busy=%b done=%b want 1 0",
                         i, busy8, done8);
            end
            total++;
            if (diff8 !== last_d || bout8 !== last_b) begin
                bad++;
                $display("FAIL hold bit%0d: diff=%h bout=%b want %h %b",
                         i, diff8, bout8, last_d, last_b);
            end
            ser[i] = sd8;
            @(negedge clk);
        end
        total++;
        if (done8 !== 1'b1 || busy8 !== 1'b0) begin
            bad++;
            $display("FAIL done: done=%b busy=%b want 1 0", done8, busy8);
        end
        total++;
        if (diff8 !== ed || bout8 !== eb) begin
            bad++;
            $display("FAIL result %h-%h-%b: diff=%h bout=%b want %h %b",
                     av, bv, bi, diff8, bout8, ed, eb);
        end
        last_d = ed;
        last_b = eb;
        bin8 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        #1;
        total++;
        if ({busy8, done8, diff8, bout8, sd8, sb8} !== 13'd0) begin
            bad++;
            $display("FAIL reset8: busy=%b done=%b diff=%h bout=%b",
                     busy8, done8, diff8, bout8);
        end
        total++;
        if ({busy1, done1, diff1, bout1, sd1, sb1} !== 6'd0) begin
            bad++;
            $display("FAIL reset1: busy=%b done=%b diff=%b bout=%b",
                     busy1, done1, diff1, bout1);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            bad++;
            $display("FAIL idle: busy=%b done=%b want 0 0", busy8, done8);
        end
    endtask

    task automatic test_basic();
        logic [7:0] ser;
        run8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, ser);
        total++;
        if (ser !== 8'h02) begin
            bad++;
            $display("FAIL ser_diff seq: got %b want 00000010", ser);
        end
    endtask

    task automatic test_borrow();
        logic [7:0] ser;
        run8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, ser);
        run8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, ser);
        run8(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, ser);
        total++;
        if (ser !== 8'hFE) begin
            bad++;
            $display("FAIL ser_diff FF-0-1: got %b want 11111110", ser);
        end
    endtask

    task automatic test_ignore_start();
        int pulses = 0;
        logic [7:0] ser;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) begin
                start8 = 1'b1; a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            if (done8) pulses++;
        end
        bin8 = 1'b0;
        total++;
        if (diff8 !== 8'h7F || bout8 !== 1'b0) begin
            bad++;
            $display("FAIL ignore result: diff=%h bout=%b want 7f 0",
                     diff8, bout8);
        end
        total++;
        if (pulses !== 1) begin
            bad++;
            $display("FAIL ignore pulses: got %0d want 1", pulses);
        end
        last_d = 8'h7F;
        last_b = 1'b0;
        run8(8'h44, 8'h11, 1'b0, 8'h33, 1'b0, ser);
    endtask

    task automatic test_reset_mid();
        logic [7:0] ser;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; bin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy8, done8, diff8, bout8, sd8, sb8} !== 13'd0) begin
            bad++;
            $display("FAIL abort: busy=%b done=%b diff=%h bout=%b sd=%b sb=%b",
                     busy8, done8, diff8, bout8, sd8, sb8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                bad++;
                $display("FAIL post-abort c%0d: done=%b busy=%b want 0 0",
                         i, done8, busy8);
            end
        end
        last_d = 8'h00;
        last_b = 1'b0;
        run8(8'h20, 8'h10, 1'b0, 8'h10, 1'b0, ser);
    endtask

    task automatic test_width1();
        logic [1:0] exp1 [8] = '{2'b00, 2'b11, 2'b11, 2'b01,
                                 2'b10, 2'b00, 2'b00, 2'b11};
        logic [2:0] k;
        for (int i = 0; i < 8; i++) begin
            k = 3'(i);
            @(negedge clk);
            start1 = 1'b1; a1 = k[2]; b1 = k[1]; bin1 = k[0];
            @(negedge clk);
            start1 = 1'b0;
            total++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                bad++;
                $display("FAIL w1 busy %b: busy=%b done=%b", k, busy1, done1);
            end
            @(negedge clk);
            total++;
            if (done1 !== 1'b1 || {diff1, bout1} !== exp1[i]) begin
                bad++;
                $display("FAIL w1 abc=%b: done=%b diff,bout=%b%b want %b",
                         k, done1, diff1, bout1, exp1[i]);
            end
        end
    endtask

    task automatic test_random();
        int d0, s0;
        logic [7:0] av, bv, ser;
        logic       bi;
        logic [8:0] full;
        d0 = done_cnt;
        s0 = start_cnt;
        for (int n = 0; n < 1000; n++) begin
            av = 8'($urandom);
            bv = 8'($urandom);
            bi = 1'($urandom);
            full = {1'b0, av} - {1'b0, bv} - {8'd0, bi};
            run8(av, bv, bi, full[7:0], full[8], ser);
        end
        @(negedge clk);
        total++;
        if (done_cnt - d0 !== start_cnt - s0) begin
            bad++;
            $display("FAIL done count: got %0d want %0d",
                     done_cnt - d0, start_cnt - s0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_ignore_start();
        test_reset_mid();
        test_width1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
